// File: rtl/status_cam_search.sv
// Writable status lookup table with a multi-lane, early-exit key search.
// Returns hit flag and lowest matching index over a valid/ready handshake.
module status_cam_search #(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 256,
  parameter  int LANES  = 4,
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              clr_en,
  input  logic [IDX_W-1:0]  clr_idx,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DATA_W-1:0] req_key,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_hit,
  output logic [IDX_W-1:0]  rsp_idx,
  output logic              busy
);

  localparam int NCHUNK = DEPTH / LANES;
  localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(NCHUNK - 1);

  if ((LANES < 1) || (LANES > DEPTH) || ((DEPTH % LANES) != 0)) begin : g_cfg_err
    $error("status_cam_search: DEPTH must be a non-zero multiple of LANES");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   chunk_q, chunk_d;
  logic [DATA_W-1:0]  key_q;
  logic [DATA_W-1:0]  mem_q [DEPTH];
  logic [DEPTH-1:0]   valid_q;
  logic               rsp_hit_q;
  logic [IDX_W-1:0]   rsp_idx_q;
  logic               hit_c;
  logic [IDX_W-1:0]   hit_idx_c;
  logic               load_rsp;
  logic               accept;

  function automatic logic [IDX_W-1:0] lane_idx(input logic [CNT_W-1:0] chunk, input int lane);
    return IDX_W'(int'(chunk) * LANES + lane);
  endfunction

  assign accept = (state_q == IDLE) && req_valid;

  // Table storage: data is never reset, only the valid bits are
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_idx] <= wr_data;
  end

  // Clear is applied after write so it wins on a same-index collision
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
    end else begin
      if (wr_en)  valid_q[wr_idx]  <= 1'b1;
      if (clr_en) valid_q[clr_idx] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) key_q <= req_key;
  end

  // Lane compare: walk high to low so the lowest matching lane ends up selected
  always_comb begin
    hit_c     = 1'b0;
    hit_idx_c = '0;
    for (int l = LANES - 1; l >= 0; l--) begin
      if (valid_q[lane_idx(chunk_q, l)] && (mem_q[lane_idx(chunk_q, l)] == key_q)) begin
        hit_c     = 1'b1;
        hit_idx_c = lane_idx(chunk_q, l);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    chunk_d  = chunk_q;
    load_rsp = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d = SEARCH;
          chunk_d = '0;
        end
      end
      SEARCH: begin
        if (hit_c || (chunk_q == LAST_CHUNK)) begin
          state_d  = RESP;
          load_rsp = 1'b1;
        end else begin
          chunk_d = chunk_q + CNT_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      chunk_q   <= '0;
      rsp_hit_q <= 1'b0;
      rsp_idx_q <= '0;
    end else begin
      state_q <= state_d;
      chunk_q <= chunk_d;
      if (load_rsp) begin
        rsp_hit_q <= hit_c;
        rsp_idx_q <= hit_idx_c;
      end
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign busy      = (state_q != IDLE);
  assign rsp_hit   = rsp_hit_q;
  assign rsp_idx   = rsp_idx_q;

endmodule

// File: tb/tb_status_cam_search.sv
// Directed bench for status_cam_search at default parameters (DEPTH 256, LANES 4).
module tb_status_cam_search;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 256;
  localparam int LANES  = 4;
  localparam int IDX_W  = 8;

  logic              clk;
  logic              reset_n;
  logic              wr_en;
  logic [IDX_W-1:0]  wr_idx;
  logic [DATA_W-1:0] wr_data;
  logic              clr_en;
  logic [IDX_W-1:0]  clr_idx;
  logic              req_valid;
  logic              req_ready;
  logic [DATA_W-1:0] req_key;
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_hit;
  logic [IDX_W-1:0]  rsp_idx;
  logic              busy;

  int tests = 0;
  int fails = 0;

  status_cam_search #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .LANES (LANES)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .wr_en    (wr_en),
    .wr_idx   (wr_idx),
    .wr_data  (wr_data),
    .clr_en   (clr_en),
    .clr_idx  (clr_idx),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_key  (req_key),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_hit  (rsp_hit),
    .rsp_idx  (rsp_idx),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_entry(input logic [IDX_W-1:0] idx, input logic [DATA_W-1:0] data);
    wr_en   = 1'b1;
    wr_idx  = idx;
    wr_data = data;
    tick();
    wr_en   = 1'b0;
  endtask

  // Returns one cycle after the accept edge
  task automatic start_search(input logic [DATA_W-1:0] key);
    req_valid = 1'b1;
    req_key   = key;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int max, output int n);
    n = 0;
    while (!rsp_valid && n < max) begin
      tick();
      n++;
    end
  endtask

  task automatic take_rsp();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  int  n;
  bit  seen;

  initial begin
    reset_n   = 1'b0;
    wr_en     = 1'b0;
    wr_idx    = '0;
    wr_data   = '0;
    clr_en    = 1'b0;
    clr_idx   = '0;
    req_valid = 1'b0;
    req_key   = '0;
    rsp_ready = 1'b0;
    repeat (3) tick();

    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_hit",   32'(rsp_hit),   32'd0);
    check("rst_rsp_idx",   32'(rsp_idx),   32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    reset_n = 1'b1;
    tick();

    // Empty table: full scan miss
    start_search(8'h01);
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_req_ready", 32'(req_ready), 32'd0);
    wait_rsp(100, n);
    check("t1_latency", 32'(n), 32'd64);
    check("t1_hit", 32'(rsp_hit), 32'd0);
    check("t1_idx", 32'(rsp_idx), 32'd0);
    take_rsp();
    check("t1_idle", 32'(req_ready), 32'd1);

    // First-chunk hits
    write_entry(8'd0, 8'h01);
    write_entry(8'd1, 8'h02);
    write_entry(8'd2, 8'h03);
    start_search(8'h03);
    wait_rsp(100, n);
    check("t2_latency", 32'(n), 32'd1);
    check("t2_hit", 32'(rsp_hit), 32'd1);
    check("t2_idx", 32'(rsp_idx), 32'd2);
    take_rsp();
    start_search(8'h01);
    wait_rsp(100, n);
    check("t2b_latency", 32'(n), 32'd1);
    check("t2b_idx", 32'(rsp_idx), 32'd0);
    take_rsp();

    // Duplicates: lowest index wins, found in chunk 2
    write_entry(8'd9, 8'h5A);
    write_entry(8'd200, 8'h5A);
    start_search(8'h5A);
    wait_rsp(100, n);
    check("t3_latency", 32'(n), 32'd3);
    check("t3_hit", 32'(rsp_hit), 32'd1);
    check("t3_idx", 32'(rsp_idx), 32'd9);

    // Back-pressure on the response
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t4_rsp_valid", 32'(rsp_valid), 32'd1);
      check("t4_hit", 32'(rsp_hit), 32'd1);
      check("t4_idx", 32'(rsp_idx), 32'd9);
      check("t4_req_ready", 32'(req_ready), 32'd0);
    end
    take_rsp();
    check("t4_release_ready", 32'(req_ready), 32'd1);
    check("t4_release_valid", 32'(rsp_valid), 32'd0);
    check("t4_release_busy", 32'(busy), 32'd0);

    // Clear idx 9 before chunk 2 is compared
    start_search(8'h5A);
    clr_en  = 1'b1;
    clr_idx = 8'd9;
    tick();
    clr_en  = 1'b0;
    wait_rsp(100, n);
    check("t5_latency", 32'(n + 1), 32'd51);
    check("t5_hit", 32'(rsp_hit), 32'd1);
    check("t5_idx", 32'(rsp_idx), 32'd200);
    take_rsp();

    // Same-cycle write and clear: entry stays invalid
    wr_en   = 1'b1;
    wr_idx  = 8'd9;
    wr_data = 8'h5A;
    clr_en  = 1'b1;
    clr_idx = 8'd9;
    tick();
    wr_en   = 1'b0;
    clr_en  = 1'b0;
    start_search(8'h5A);
    wait_rsp(100, n);
    check("t5b_latency", 32'(n), 32'd51);
    check("t5b_idx", 32'(rsp_idx), 32'd200);
    take_rsp();

    // Write to a not-yet-scanned chunk is seen
    start_search(8'h5A);
    write_entry(8'd100, 8'h5A);
    wait_rsp(100, n);
    check("t5c_latency", 32'(n + 1), 32'd26);
    check("t5c_idx", 32'(rsp_idx), 32'd100);
    take_rsp();

    // Write to an already-scanned chunk is not seen
    start_search(8'h5A);
    tick();
    write_entry(8'd0, 8'h5A);
    wait_rsp(100, n);
    check("t5d_latency", 32'(n + 2), 32'd26);
    check("t5d_idx", 32'(rsp_idx), 32'd100);
    take_rsp();
    start_search(8'h5A);
    wait_rsp(100, n);
    check("t5e_latency", 32'(n), 32'd1);
    check("t5e_idx", 32'(rsp_idx), 32'd0);
    take_rsp();

    // Reset in the middle of a search
    start_search(8'h77);
    repeat (4) tick();
    reset_n = 1'b0;
    #1;
    check("t6_rst_ready", 32'(req_ready), 32'd1);
    check("t6_rst_valid", 32'(rsp_valid), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    repeat (2) tick();
    reset_n = 1'b1;
    seen = 1'b0;
    repeat (80) begin
      tick();
      if (rsp_valid) seen = 1'b1;
    end
    check("t6_no_rsp", 32'(seen), 32'd0);
    check("t6_ready", 32'(req_ready), 32'd1);
    start_search(8'h03);
    wait_rsp(100, n);
    check("t6_clear_lat", 32'(n), 32'd64);
    check("t6_clear_hit", 32'(rsp_hit), 32'd0);
    take_rsp();
    start_search(8'h5A);
    wait_rsp(100, n);
    check("t6_clear2_lat", 32'(n), 32'd64);
    check("t6_clear2_hit", 32'(rsp_hit), 32'd0);
    check("t6_clear2_idx", 32'(rsp_idx), 32'd0);
    take_rsp();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
